scr1_dp_mem_ctrl: RTL and testbench

- Controller in front of the team's dual-port synchronous TCM (32-bit words, per-byte write enables, 1-cycle registered read on both ports).
- Port A is dedicated to instruction fetch.
- Port B is shared, through round-robin arbitration, between the core data interface (requester 0) and an external loader/debug bus (requester 1).
- An optional post-reset clear engine zero-fills the array before any requester is served.

---
 rtl/scr1_dp_mem_ctrl_if.sv | 65 ++++++
 rtl/scr1_dp_mem_ctrl.sv | 103 ++++++++++
 tb/tb_scr1_dp_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_dp_mem_ctrl_if.sv
// Bus bundle between the dual-port TCM controller, its requesters and the TCM macro.
// The slave side is the controller; the master side is everything around it.
interface scr1_dp_mem_ctrl_if #(
    parameter int WAW = 14
);
    logic           i_req;
    logic [WAW-1:0] i_addr;
    logic           i_ack;
    logic           i_rvalid;
    logic [31:0]    i_rdata;

    logic           r0_req;
    logic           r0_we;
    logic [3:0]     r0_be;
    logic [WAW-1:0] r0_addr;
    logic [31:0]    r0_wdata;
    logic           r0_ack;
    logic           r0_rvalid;
    logic [31:0]    r0_rdata;

    logic           r1_req;
    logic           r1_we;
    logic [3:0]     r1_be;
    logic [WAW-1:0] r1_addr;
    logic [31:0]    r1_wdata;
    logic           r1_ack;
    logic           r1_rvalid;
    logic [31:0]    r1_rdata;

    logic           mem_rena;
    logic [WAW-1:0] mem_addra;
    logic [31:0]    mem_qa;
    logic           mem_renb;
    logic           mem_wenb;
    logic [3:0]     mem_webb;
    logic [WAW-1:0] mem_addrb;
    logic [31:0]    mem_datab;
    logic [31:0]    mem_qb;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rvalid, i_rdata,
        input  r0_req, r0_we, r0_be, r0_addr, r0_wdata,
        output r0_ack, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_be, r1_addr, r1_wdata,
        output r1_ack, r1_rvalid, r1_rdata,
        output mem_rena, mem_addra,
        input  mem_qa,
        output mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab,
        input  mem_qb
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rvalid, i_rdata,
        output r0_req, r0_we, r0_be, r0_addr, r0_wdata,
        input  r0_ack, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_be, r1_addr, r1_wdata,
        input  r1_ack, r1_rvalid, r1_rdata,
        input  mem_rena, mem_addra,
        output mem_qa,
        input  mem_renb, mem_wenb, mem_webb, mem_addrb, mem_datab,
        output mem_qb
    );
endinterface

// File: rtl/scr1_dp_mem_ctrl.sv
// Dual-port TCM controller: port A for fetch, port B round-robin shared by data (r0)
// and loader/debug (r1), with an optional zero-fill of the array after reset.
//
// state    | meaning
// ST_CLEAR | zero-filling one word per cycle, all requesters stalled
// ST_RUN   | normal service of fetch and port-B requesters
module scr1_dp_mem_ctrl #(
    parameter logic [31:0] SCR1_SIZE = 32'h00010000,
    parameter bit          CLEAR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    scr1_dp_mem_ctrl_if.slave bus
);
    localparam int AW  = $clog2(SCR1_SIZE);
    localparam int WAW = AW - 2;
    localparam logic [WAW-1:0] LAST_WORD = WAW'((SCR1_SIZE >> 2) - 32'd1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t         state;
    logic [WAW-1:0] wcnt;
    logic           rr_last;
    logic           resp_vld;
    logic           resp_idx;
    logic           i_rvalid_q;

    logic           run;
    logic           gnt0;
    logic           gnt1;
    logic           gnt_any;
    logic           gnt_we;
    logic [WAW-1:0] b_addr;
    logic [3:0]     b_be;
    logic [31:0]    b_wdata;

    assign run = (state == ST_RUN);

    // On a conflict the requester that did not win last time gets the port.
    assign gnt0    = run && bus.r0_req && (!bus.r1_req || rr_last);
    assign gnt1    = run && bus.r1_req && (!bus.r0_req || !rr_last);
    assign gnt_any = gnt0 || gnt1;

    assign gnt_we  = gnt1 ? bus.r1_we    : bus.r0_we;
    assign b_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
    assign b_be    = gnt1 ? bus.r1_be    : bus.r0_be;
    assign b_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;

    assign bus.i_ack     = run && bus.i_req;
    assign bus.mem_rena  = run && bus.i_req;
    assign bus.mem_addra = bus.i_addr;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.i_rdata   = bus.mem_qa;

    assign bus.r0_ack    = gnt0;
    assign bus.r1_ack    = gnt1;
    assign bus.mem_wenb  = run ? (gnt_any && gnt_we) : 1'b1;
    assign bus.mem_renb  = gnt_any && !gnt_we;
    assign bus.mem_webb  = run ? b_be    : 4'hF;
    assign bus.mem_addrb = run ? b_addr  : wcnt;
    assign bus.mem_datab = run ? b_wdata : 32'h0;

    assign bus.r0_rvalid = resp_vld && !resp_idx;
    assign bus.r1_rvalid = resp_vld && resp_idx;
    assign bus.r0_rdata  = bus.mem_qb;
    assign bus.r1_rdata  = bus.mem_qb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR_EN ? ST_CLEAR : ST_RUN;
            wcnt      <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == LAST_WORD) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: init_done <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last    <= 1'b1;
            resp_vld   <= 1'b0;
            resp_idx   <= 1'b0;
            i_rvalid_q <= 1'b0;
        end else begin
            i_rvalid_q <= run && bus.i_req;
            resp_vld   <= gnt_any && !gnt_we;
            if (gnt_any) begin
                rr_last  <= gnt1;
                resp_idx <= gnt1;
            end
        end
    end
endmodule

// File: tb/tb_scr1_dp_mem_ctrl.sv
// Bench for scr1_dp_mem_ctrl with a 64-byte TCM: directed clear/reset/arbitration cases
// followed by random traffic, checked against a word-array reference and response queues.
`timescale 1ns/1ps
module tb_scr1_dp_mem_ctrl;
    localparam logic [31:0] SIZE = 32'd64;
    localparam int WAW = 4;
    localparam int NW  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic init_done;

    always #5 clk = ~clk;

    scr1_dp_mem_ctrl_if #(.WAW(WAW)) bus ();

    scr1_dp_mem_ctrl #(.SCR1_SIZE(SIZE), .CLEAR_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .bus       (bus)
    );

    // TCM macro: synchronous read on both ports, per-byte write on port B.
    logic [31:0] tcm [NW];
    initial for (int i = 0; i < NW; i++) tcm[i] <= $urandom;
    always @(posedge clk) begin
        if (bus.mem_rena) bus.mem_qa <= tcm[bus.mem_addra];
        if (bus.mem_renb) bus.mem_qb <= tcm[bus.mem_addrb];
        if (bus.mem_wenb)
            for (int b = 0; b < 4; b++)
                if (bus.mem_webb[b]) tcm[bus.mem_addrb][8*b +: 8] <= bus.mem_datab[8*b +: 8];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;
    bit pend0 = 1'b0;
    bit pend1 = 1'b0;
    int last_win = 1;
    logic [31:0] ref_mem [NW];

    typedef struct {
        int          stamp;
        int          idx;
        logic [31:0] data;
    } rd_t;
    rd_t bq[$];
    rd_t fq[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_i(input bit req, input int addr);
        bus.i_req  = req;
        bus.i_addr = WAW'(addr);
    endtask

    task automatic set_r0(input bit req, input bit we, input logic [3:0] be, input int addr, input logic [31:0] d);
        bus.r0_req = req; bus.r0_we = we; bus.r0_be = be; bus.r0_addr = WAW'(addr); bus.r0_wdata = d;
    endtask

    task automatic set_r1(input bit req, input bit we, input logic [3:0] be, input int addr, input logic [31:0] d);
        bus.r1_req = req; bus.r1_we = we; bus.r1_be = be; bus.r1_addr = WAW'(addr); bus.r1_wdata = d;
    endtask

    task automatic clear_phase(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("clr_wenb", bus.mem_wenb, 1'b1);
            chk("clr_webb", bus.mem_webb, 4'hF);
            chk("clr_data", bus.mem_datab, 32'h0);
            chk("clr_addr", bus.mem_addrb, k);
            chk("clr_init_done", init_done, 1'b0);
            chk("clr_r0_ack", bus.r0_ack, 1'b0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
        last_win = 1;
    endtask

    // Reference: grant order from the round-robin rule, memory as a plain word array.
    initial forever begin
        @(negedge clk);
        #1;
        if (chk_on) begin
            int          g;
            int          a;
            logic        w;
            logic [3:0]  be;
            logic [31:0] wd;
            rd_t         e;
            g = -1;
            if (bus.r0_req && bus.r1_req) g = (last_win == 0) ? 1 : 0;
            else if (bus.r0_req)          g = 0;
            else if (bus.r1_req)          g = 1;
            chk("i_ack", bus.i_ack, bus.i_req);
            chk("r0_ack", bus.r0_ack, g == 0);
            chk("r1_ack", bus.r1_ack, g == 1);
            if (bus.i_req) begin
                e.stamp = cyc; e.idx = 2; e.data = ref_mem[int'(bus.i_addr)];
                fq.push_back(e);
            end
            if (g >= 0) begin
                w  = (g == 1) ? bus.r1_we    : bus.r0_we;
                be = (g == 1) ? bus.r1_be    : bus.r0_be;
                a  = (g == 1) ? int'(bus.r1_addr) : int'(bus.r0_addr);
                wd = (g == 1) ? bus.r1_wdata : bus.r0_wdata;
                if (w) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e.stamp = cyc; e.idx = g; e.data = ref_mem[a];
                    bq.push_back(e);
                end
                last_win = g;
            end
            pend0 = bus.r0_req && (g != 0);
            pend1 = bus.r1_req && (g != 1);
        end
    end

    // Response monitor: each queued read must come back exactly one cycle later.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            bit  ev;
            int  idx;
            rd_t e;
            ev = (fq.size() > 0) && (fq[0].stamp == cyc - 1);
            chk("i_rvalid", bus.i_rvalid, ev);
            if (ev) begin
                e = fq.pop_front();
                chk("i_rdata", bus.i_rdata, e.data);
            end
            ev  = (bq.size() > 0) && (bq[0].stamp == cyc - 1);
            idx = ev ? bq[0].idx : -1;
            chk("r0_rvalid", bus.r0_rvalid, idx == 0);
            chk("r1_rvalid", bus.r1_rvalid, idx == 1);
            if (ev) begin
                e = bq.pop_front();
                if (idx == 0) chk("r0_rdata", bus.r0_rdata, e.data);
                else          chk("r1_rdata", bus.r1_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_i(0, 0);
        set_r0(1, 0, 4'h0, 0, 32'h0);
        set_r1(0, 0, 4'h0, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1 chk("rst_init_done", init_done, 1'b0);
        chk("rst_r0_rvalid", bus.r0_rvalid, 1'b0);
        chk("rst_i_rvalid", bus.i_rvalid, 1'b0);
        rst_n = 1'b1;

        // Abort the clear at wcnt=7, then let a full clear run.
        clear_phase(8);
        #1 rst_n = 1'b0;
        #1 chk("abort_addr", bus.mem_addrb, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_phase(16);
        @(negedge clk);
        chk("init_done_rise", init_done, 1'b1);
        chk("first_r0_ack", bus.r0_ack, 1'b1);
        chk("first_r1_ack", bus.r1_ack, 1'b0);
        next();
        set_r0(0, 0, 4'h0, 0, 32'h0);
        @(negedge clk);
        chk("first_r0_rvalid", bus.r0_rvalid, 1'b1);
        chk("first_r0_rdata", bus.r0_rdata, 32'h0);
        chk("first_r1_rvalid", bus.r1_rvalid, 1'b0);
        model_reset();
        last_win = 0;

        next(); chk_on = 1'b1;
        set_r0(1, 1, 4'b0011, 3, 32'hDEADBEEF);
        next(); set_r0(1, 0, 4'h0, 3, 32'h0);
        next(); set_r0(1, 1, 4'hF, 2, 32'hA5A50F0F);
        next(); set_r0(1, 1, 4'h0, 2, 32'hFFFFFFFF);
        next(); set_r0(1, 0, 4'h0, 2, 32'h0);
        next(); set_r0(1, 1, 4'hF, 5, 32'hCAFE0005);
        next(); set_r0(0, 0, 4'h0, 0, 32'h0);
        set_i(1, 5); set_r1(1, 1, 4'hF, 5, 32'h12345678);
        next(); set_r1(0, 0, 4'h0, 0, 32'h0);
        next(); set_i(0, 0);
        next(); next();
        chk_on = 1'b0;
        chk("drain_1", fq.size() + bq.size(), 0);

        // Second reset: conflicting readers from a fresh arbiter.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_phase(16);
        @(negedge clk);
        chk("init_done_2", init_done, 1'b1);
        model_reset();
        next(); chk_on = 1'b1;
        set_r0(1, 0, 4'h0, 1, 32'h0);
        set_r1(1, 0, 4'h0, 9, 32'h0);
        repeat (3) next();

        for (int n = 0; n < 400; n++) begin
            next();
            set_i(($urandom_range(0, 1) == 1), $urandom_range(0, NW - 1));
            if (!pend0)
                set_r0(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom),
                       $urandom_range(0, NW - 1), $urandom);
            if (!pend1)
                set_r1(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom),
                       $urandom_range(0, NW - 1), $urandom);
        end
        while (pend0 || pend1) begin
            next();
            if (!pend0) set_r0(0, 0, 4'h0, 0, 32'h0);
            if (!pend1) set_r1(0, 0, 4'h0, 0, 32'h0);
            set_i(0, 0);
        end
        next();
        set_r0(0, 0, 4'h0, 0, 32'h0);
        set_r1(0, 0, 4'h0, 0, 32'h0);
        set_i(0, 0);
        next(); next();
        chk_on = 1'b0;
        chk("drain_2", fq.size() + bq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
